// File: rtl/cnn_pkg.sv
// Shared constants and types for the dense (fully connected) classifier stage.
package cnn_pkg;

  localparam int N_FEAT  = 800;
  localparam int N_CLASS = 10;
  localparam int ACT_W   = 8;
  localparam int ACC_W   = 32;
  localparam int PROD_W  = 2 * ACT_W;
  localparam int FEAT_AW = 12;
  localparam int W_AW    = 13;
  localparam int CLS_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_MAC,
    ST_STORE,
    ST_DONE
  } state_t;

  // Sign-extend a 16-bit product to the accumulator width.
  function automatic logic [ACC_W-1:0] sext_prod(input logic [PROD_W-1:0] p);
    return {{(ACC_W - PROD_W){p[PROD_W-1]}}, p};
  endfunction

endpackage

// File: rtl/dense_mac.sv
// Signed 8x8 multiplier feeding a 32-bit wrapping accumulator.
// load has priority over en; load presets the accumulator with a bias.
module dense_mac
  import cnn_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic                    en,
  input  logic signed [ACC_W-1:0] load_val,
  input  logic signed [ACT_W-1:0] feat,
  input  logic signed [ACT_W-1:0] weight,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [PROD_W-1:0] prod;

  // Full-precision signed product; 8x8 signed always fits in 16 bits.
  always_comb begin
    prod = feat * weight;
  end

  // Accumulator: bias preload, then two's complement wrap-around accumulation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (load) begin
      acc <= load_val;
    end else if (en) begin
      acc <= acc + $signed(sext_prod(prod));
    end
  end

endmodule

// File: rtl/dense_engine.sv
// Dense layer engine: for each of 10 classes, preload the bias, stream
// 800 feature/weight pairs through the MAC, store the score and track the
// running argmax. Memories are external with one cycle of read latency, so
// every address is presented one cycle before its data is consumed.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; bias writes accepted; addresses held at 0
// ST_INIT  | acc <= bias[cls]; fetch feature 0 / weight cls*800
// ST_MAC   | 800 cycles, accumulate pair k, fetch pair k+1
// ST_STORE | score[cls] <= acc; update max/digit; next class or finish
// ST_DONE  | one-cycle done pulse, then back to ST_IDLE
module dense_engine
  import cnn_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [FEAT_AW-1:0]   buf_b_addr,
  input  logic [ACT_W-1:0]     buf_b_rd_data,
  output logic [W_AW-1:0]      dw_addr,
  input  logic [ACT_W-1:0]     dw_rd_data,
  input  logic                 bias_wr_en,
  input  logic [CLS_W-1:0]     bias_wr_idx,
  input  logic [ACC_W-1:0]     bias_wr_data,
  input  logic [CLS_W-1:0]     score_rd_idx,
  output logic [ACC_W-1:0]     score_rd_data,
  output logic                 busy,
  output logic                 done,
  output logic [CLS_W-1:0]     digit
);

  state_t                  state, state_nxt;
  logic [CLS_W-1:0]        cls;
  logic [FEAT_AW-1:0]      feat_idx;
  logic [W_AW-1:0]         w_ptr;
  logic                    mac_tc;
  logic                    last_cls;
  logic                    mac_load;
  logic                    mac_en;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] max_q;
  logic [ACC_W-1:0]        bias_q  [N_CLASS];
  logic [ACC_W-1:0]        score_q [N_CLASS];
  logic [CLS_W-1:0]        digit_q;

  assign mac_tc   = (feat_idx == FEAT_AW'(N_FEAT - 1));
  assign last_cls = (cls == CLS_W'(N_CLASS - 1));
  assign digit    = digit_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; start is only looked at in ST_IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_INIT;
      ST_INIT:  state_nxt = ST_MAC;
      ST_MAC:   if (mac_tc) state_nxt = ST_STORE;
      ST_STORE: state_nxt = last_cls ? ST_DONE : ST_INIT;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Outputs and MAC controls decoded from the current state.
  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    mac_load   = 1'b0;
    mac_en     = 1'b0;
    buf_b_addr = '0;
    dw_addr    = '0;
    case (state)
      ST_INIT: begin
        busy     = 1'b1;
        mac_load = 1'b1;
        dw_addr  = w_ptr;
      end
      ST_MAC: begin
        busy       = 1'b1;
        mac_en     = 1'b1;
        buf_b_addr = feat_idx + FEAT_AW'(1);
        dw_addr    = w_ptr + W_AW'(1);
      end
      ST_STORE: begin
        busy = 1'b1;
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Class, feature and weight-pointer counters. w_ptr advances once per MAC
  // cycle, so after a class it already sits at the next class's base.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cls      <= '0;
      feat_idx <= '0;
      w_ptr    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          cls      <= '0;
          feat_idx <= '0;
          w_ptr    <= '0;
        end
        ST_INIT: feat_idx <= '0;
        ST_MAC: begin
          feat_idx <= feat_idx + FEAT_AW'(1);
          w_ptr    <= w_ptr + W_AW'(1);
        end
        ST_STORE: if (!last_cls) cls <= cls + CLS_W'(1);
        default: ;
      endcase
    end
  end

  // Bias register file, writable only while idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CLASS; i++) bias_q[i] <= '0;
    end else if (state == ST_IDLE && bias_wr_en && bias_wr_idx < CLS_W'(N_CLASS)) begin
      bias_q[bias_wr_idx] <= bias_wr_data;
    end
  end

  dense_mac u_mac (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (mac_load),
    .en       (mac_en),
    .load_val ($signed(bias_q[cls])),
    .feat     ($signed(buf_b_rd_data)),
    .weight   ($signed(dw_rd_data)),
    .acc      (acc)
  );

  // Score capture and argmax; strict compare keeps the lowest index on ties.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CLASS; i++) score_q[i] <= '0;
      max_q   <= '0;
      digit_q <= '0;
    end else if (state == ST_STORE) begin
      score_q[cls] <= acc;
      if (cls == '0 || acc > max_q) begin
        max_q   <= acc;
        digit_q <= cls;
      end
    end
  end

  // Combinational score readback; out-of-range indices read as zero.
  always_comb begin
    score_rd_data = '0;
    if (score_rd_idx < CLS_W'(N_CLASS)) score_rd_data = score_q[score_rd_idx];
  end

endmodule

// File: tb/tb_dense_engine.sv
// Directed bench for dense_engine: table of whole-run vectors plus
// hand-written sequences for re-start, late bias write and mid-run reset.
module tb_dense_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [11:0] buf_b_addr;
  logic [7:0]  buf_b_rd_data;
  logic [12:0] dw_addr;
  logic [7:0]  dw_rd_data;
  logic        bias_wr_en;
  logic [3:0]  bias_wr_idx;
  logic [31:0] bias_wr_data;
  logic [3:0]  score_rd_idx;
  logic [31:0] score_rd_data;
  logic        busy;
  logic        done;
  logic [3:0]  digit;

  logic [7:0] feat_mem [800];
  logic [7:0] w_mem    [8000];

  int errors = 0;
  int checks = 0;
  int exp_sc [10];

  typedef struct {
    int f;          // value of every feature
    int w;          // weight value for ordinary classes
    int sp_cls;     // class with a different weight (-1: none)
    int w_sp;       // weight value for sp_cls
    int b_idx;      // class with non-zero bias (-1: none)
    int b_val;
    int exp_digit;
    int chk_idx;    // one hand-computed score
    int chk_val;
  } vec_t;

  vec_t vecs [6];

  dense_engine dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .buf_b_addr    (buf_b_addr),
    .buf_b_rd_data (buf_b_rd_data),
    .dw_addr       (dw_addr),
    .dw_rd_data    (dw_rd_data),
    .bias_wr_en    (bias_wr_en),
    .bias_wr_idx   (bias_wr_idx),
    .bias_wr_data  (bias_wr_data),
    .score_rd_idx  (score_rd_idx),
    .score_rd_data (score_rd_data),
    .busy          (busy),
    .done          (done),
    .digit         (digit)
  );

  always #5 clk = ~clk;

  // Memories with one cycle of read latency.
  always @(posedge clk) begin
    buf_b_rd_data <= (buf_b_addr < 12'd800) ? feat_mem[buf_b_addr] : 8'd0;
    dw_rd_data    <= (dw_addr < 13'd8000) ? w_mem[dw_addr] : 8'd0;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, $signed(act), $signed(exp));
    end
  endtask

  task automatic fill(input int f, input int w, input int sp_cls, input int w_sp);
    for (int i = 0; i < 800; i++) feat_mem[i] = 8'(f);
    for (int c = 0; c < 10; c++)
      for (int i = 0; i < 800; i++) w_mem[c*800 + i] = 8'((c == sp_cls) ? w_sp : w);
  endtask

  task automatic wr_bias(input int idx, input int val);
    @(negedge clk);
    bias_wr_en   = 1'b1;
    bias_wr_idx  = 4'(idx);
    bias_wr_data = 32'(val);
    @(negedge clk);
    bias_wr_en = 1'b0;
  endtask

  // Cycle 0 is the idle cycle with start high; inputs for cycle n are driven
  // at the negedge inside cycle n, outputs observed at that same negedge.
  task automatic run(input int pulse_at, input int bwr_at, input int rst_at,
                     output int done_cyc);
    done_cyc = -1;
    @(negedge clk);
    start = 1'b1;
    for (int n = 1; n <= 8100; n++) begin
      @(negedge clk);
      start      = (n == pulse_at);
      bias_wr_en = (n == bwr_at);
      if (n == bwr_at) begin
        bias_wr_idx  = 4'd5;
        bias_wr_data = 32'd12345;
      end
      if (rst_at > 0 && n == rst_at) rst_n = 1'b0;
      if (rst_at > 0 && n == rst_at + 1) begin
        chk("busy_after_reset", 32'(busy), 32'd0);
        chk("done_after_reset", 32'(done), 32'd0);
        chk("digit_after_reset", 32'(digit), 32'd0);
        chk("baddr_after_reset", 32'(buf_b_addr), 32'd0);
        rst_n = 1'b1;
        break;
      end
      if (n == 1) begin
        chk("busy_cycle1", 32'(busy), 32'd1);
        chk("dw_addr_init_c0", 32'(dw_addr), 32'd0);
      end
      if (n == 3209) begin
        chk("dw_addr_init_c4", 32'(dw_addr), 32'd3200);
        chk("baddr_init_c4", 32'(buf_b_addr), 32'd0);
      end
      if (n == 3210) begin
        chk("dw_addr_mac0_c4", 32'(dw_addr), 32'd3201);
        chk("baddr_mac0_c4", 32'(buf_b_addr), 32'd1);
      end
      if (n == 8018) begin
        chk("dw_addr_last_c9", 32'(dw_addr), 32'd7999);
        chk("baddr_last_c9", 32'(buf_b_addr), 32'd799);
      end
      if (done) begin
        done_cyc = n;
        chk("busy_at_done", 32'(busy), 32'd1);
        chk("dw_addr_done", 32'(dw_addr), 32'd0);
        chk("baddr_done", 32'(buf_b_addr), 32'd0);
        @(negedge clk);
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("done_pulse_width", 32'(done), 32'd0);
        break;
      end
    end
    start      = 1'b0;
    bias_wr_en = 1'b0;
  endtask

  task automatic check_scores(input string tag);
    for (int c = 0; c < 10; c++) begin
      score_rd_idx = 4'(c);
      #1;
      chk($sformatf("%s_score%0d", tag, c), score_rd_data, 32'(exp_sc[c]));
    end
    score_rd_idx = 4'd11;
    #1;
    chk($sformatf("%s_score_oob", tag), score_rd_data, 32'd0);
  endtask

  initial begin
    int dc;
    rst_n        = 1'b0;
    start        = 1'b0;
    bias_wr_en   = 1'b0;
    bias_wr_idx  = '0;
    bias_wr_data = '0;
    score_rd_idx = '0;

    //         f     w    sp  w_sp  b_idx b_val  dig chk  chk_val
    vecs[0] = '{   1,   1, -1,  0,  -1,     0,  0,  5,      800};
    vecs[1] = '{   1,   1,  7,  2,  -1,     0,  7,  7,     1600};
    vecs[2] = '{-128,-128, -1,  0,   3,     5,  3,  3, 13107205};
    vecs[3] = '{-128,-128, -1,  0,  -1,     0,  0,  9, 13107200};
    vecs[4] = '{   1,  -1, -1,  0,   4,   700,  4,  4,     -100};
    vecs[5] = '{  -1,   3,  5, -5,   2, 10000,  2,  5,     4000};

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_digit", 32'(digit), 32'd0);
    chk("rst_baddr", 32'(buf_b_addr), 32'd0);
    chk("rst_dwaddr", 32'(dw_addr), 32'd0);
    #1;
    chk("rst_score0", score_rd_data, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    for (int v = 0; v < 6; v++) begin
      fill(vecs[v].f, vecs[v].w, vecs[v].sp_cls, vecs[v].w_sp);
      for (int c = 0; c < 10; c++) begin
        wr_bias(c, (c == vecs[v].b_idx) ? vecs[v].b_val : 0);
        exp_sc[c] = ((c == vecs[v].b_idx) ? vecs[v].b_val : 0)
                  + 800 * vecs[v].f * ((c == vecs[v].sp_cls) ? vecs[v].w_sp : vecs[v].w);
      end
      run(-1, -1, -1, dc);
      chk($sformatf("v%0d_done_cycle", v), 32'(dc), 32'd8021);
      chk($sformatf("v%0d_digit", v), 32'(digit), 32'(vecs[v].exp_digit));
      score_rd_idx = 4'(vecs[v].chk_idx);
      #1;
      chk($sformatf("v%0d_hand_score", v), score_rd_data, 32'(vecs[v].chk_val));
      check_scores($sformatf("v%0d", v));
    end

    // Re-start pulse at 400 and bias write at 500 during a run are ignored.
    fill(1, 1, -1, 0);
    for (int c = 0; c < 10; c++) begin
      wr_bias(c, 0);
      exp_sc[c] = 800;
    end
    run(400, 500, -1, dc);
    chk("busyops_done_cycle", 32'(dc), 32'd8021);
    chk("busyops_digit", 32'(digit), 32'd0);
    check_scores("busyops");

    // Mid-run reset aborts, clears scores and biases; next run is clean.
    fill(-128, -128, -1, 0);
    wr_bias(3, 5);
    run(-1, -1, 3000, dc);
    chk("abort_no_done", 32'(dc), 32'hFFFF_FFFF);
    score_rd_idx = 4'd0;
    #1;
    chk("abort_score0_cleared", score_rd_data, 32'd0);
    for (int c = 0; c < 10; c++) exp_sc[c] = 13107200;
    run(-1, -1, -1, dc);
    chk("post_reset_done_cycle", 32'(dc), 32'd8021);
    chk("post_reset_digit", 32'(digit), 32'd0);
    check_scores("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
